dm_lsu: RTL and testbench

//  Load/store unit between the MEM pipeline stage and the 4 KB word data memory (dm_4k).

---
 rtl/dm_lsu.sv | 168 ++++++++++++++++
 tb/tb_dm_lsu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit between the MEM stage and a 2^AW-word data memory.
//   Latency: load 2 cycles, word store 2 cycles, byte/half store 3 cycles (RMW).
//   Backpressure: busy_o holds the core from the cycle after accept to ack; req_i is only sampled in IDLE.
// Ports: clk_i/rst_n_i (sync active-low reset), core side req_i/we_i/size_i/sext_i/addr_i/wdata_i
//   -> ack_o/rdata_o/busy_o/misalign_o; memory side mem_addr_o/mem_din_o/mem_we_o/mem_re_o <- mem_dout_i.
// Optional feature: define ALIGN_CHK_EN to reject misaligned half/word accesses with misalign_o.
module dm_lsu #(
  parameter int AW = 10,
  parameter bit BE = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [1:0]    size_i,
  input  logic          sext_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          ack_o,
  output logic [31:0]   rdata_o,
  output logic          busy_o,
  output logic          misalign_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_din_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [31:0]   mem_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

  state_t        state_q;
  logic          we_q, sext_q, ack_q, busy_q, mem_we_q, mem_re_q;
  logic [1:0]    size_q, off_q;
  logic [15:0]   wdata_q;
  logic [31:0]   rdata_q, mem_din_q;
  logic [AW-1:0] mem_addr_q;

  // Upper address bits fall outside the memory and simply wrap.
  logic unused_addr_w;
  assign unused_addr_w = ^addr_i[31:AW+2];

  // Bit offset of the addressed byte / half inside the word, honouring lane order.
  function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return BE ? {~off, 3'b000} : {off, 3'b000};
    else             return BE ? {~off[1], 4'b0000} : {off[1], 4'b0000};
  endfunction

  // Sub-word store merge; only byte and half reach the RMW path.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [4:0]  sh;
    logic [31:0] m, v;
    sh = lane_shift(sz, off);
    if (sz == 2'b00) begin
      m = 32'h0000_00FF << sh;
      v = {24'h0, wd[7:0]} << sh;
    end else begin
      m = 32'h0000_FFFF << sh;
      v = {16'h0, wd} << sh;
    end
    return (old & ~m) | v;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] off, input logic sx);
    logic [31:0] b;
    b = word >> lane_shift(sz, off);
    if (sz == 2'b00)      return {{24{sx & b[7]}}, b[7:0]};
    else if (sz == 2'b01) return {{16{sx & b[15]}}, b[15:0]};
    else                  return word;
  endfunction

`ifdef ALIGN_CHK_EN
  logic mis_w, misalign_q;
  // Size 11 is handled as a word.
  assign mis_w      = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
`ifdef ALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // Strobes default low; each state arms the ones it needs for the next cycle.
      ack_q    <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            sext_q     <= sext_i;
            size_q     <= size_i;
            off_q      <= addr_i[1:0];
            wdata_q    <= wdata_i[15:0];
            mem_addr_q <= addr_i[AW+1:2];
            busy_q     <= 1'b1;
`ifdef ALIGN_CHK_EN
            misalign_q <= mis_w;
            if (mis_w) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else
`endif
            if (we_i && size_i[1]) begin
              state_q   <= S_WR;
              mem_we_q  <= 1'b1;
              mem_din_q <= wdata_i;
            end else begin
              state_q  <= S_RD;
              mem_re_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            state_q   <= S_WR;
            mem_we_q  <= 1'b1;
            mem_din_q <= merge(mem_dout_i, wdata_q, size_q, off_q);
          end else begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            rdata_q <= extract(mem_dout_i, size_q, off_q, sext_q);
          end
        end
        S_WR: begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef ALIGN_CHK_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign mem_we_o   = mem_we_q;
  assign mem_re_o   = mem_re_q;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed + random accesses against a byte-array reference of the memory.
module tb_dm_lsu;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, req, we, sext;
  logic [1:0]    size;
  logic [31:0]   addr, wdata, rdata, mem_din, mem_dout;
  logic          ack, busy, misalign, mem_we, mem_re;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  dm_lsu #(.AW(AW), .BE(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .size_i(size), .sext_i(sext),
    .addr_i(addr), .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .busy_o(busy),
    .misalign_o(misalign), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we),
    .mem_re_o(mem_re), .mem_dout_i(mem_dout)
  );

  // Physical memory driven by the DUT.
  logic [31:0] phys [0:1023];
  always @(posedge clk) if (mem_we) phys[mem_addr] <= mem_din;
  assign mem_dout = phys[mem_addr];

  // Reference: memory as 4096 bytes, little-endian lane order.
  logic [7:0]  ref_b [0:4095];
  logic [31:0] exp_rdata;
  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    int nb, base, lat, wrn, rdn;
    logic mis;
    logic [31:0] v;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis  = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    base = int'(a[11:0]) & ~(nb - 1);
    lat  = (w && nb < 4) ? 3 : 2;
`ifdef ALIGN_CHK_EN
    if (mis) lat = 1;
`else
    mis = 1'b0;
`endif
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_b[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[base+i]) << (8*i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        exp_rdata = v;
      end
    end
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    wrn = 0; rdn = 0;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = 1'b0; addr = $urandom; wdata = $urandom;
      end
      chk("busy", 32'(busy), 32'(n <= lat));
      chk("ack", 32'(ack), 32'(n == lat));
      chk("re_we_excl", 32'(mem_re & mem_we), 32'h0);
      if (mem_we) wrn++;
      if (mem_re) rdn++;
      if (mem_we | mem_re) chk("mem_addr", 32'(mem_addr), 32'(base >> 2));
      if (n == lat) begin
        chk("rdata", rdata, exp_rdata);
        chk("misalign", 32'(misalign), 32'(mis));
      end
    end
    chk("we_pulses", 32'(wrn), 32'(w && !mis));
    chk("re_pulses", 32'(rdn), 32'(!mis && (!w || nb < 4)));
    chk("mem_word", phys[base>>2], ref_word(base >> 2));
  endtask

  initial begin
    logic [31:0] old;
    logic [4:0]  pat;
    for (int i = 0; i < 1024; i++) begin
      phys[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = phys[i][8*j +: 8];
    end
    exp_rdata = 32'h0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", mem_din, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_mem_re", 32'(mem_re), 0);
    end

    // Word store / load
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("t2_rdata", rdata, 32'hDEADBEEF);

    // Byte RMW and byte loads
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
    chk("t3_word", phys[4], 32'h1122A544);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("t3_lb_sext", rdata, 32'hFFFFFFA5);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("t3_lb_zext", rdata, 32'h000000A5);

    // Half RMW and half load
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    chk("t4_word", phys[4], 32'h80013344);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("t4_lh_sext", rdata, 32'hFFFF8001);

    // Misaligned word load
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifndef ALIGN_CHK_EN
    chk("t5_rdata", rdata, 32'h80013344);
`endif

    // req held through ACK: second access accepted only after an IDLE cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
    @(posedge clk);
    pat = '0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      pat[n-1] = ack;
      if (n == 4) req = 1'b0;
    end
    chk("b2b_ack_pattern", 32'(pat), 32'h12);
    exp_rdata = ref_word(4);
    chk("b2b_rdata", rdata, exp_rdata);
    @(negedge clk);

    // Reset during RD of a byte store abandons the write
    old = phys[5];
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h14; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("t6_in_rd", 32'(mem_re), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ack", 32'(ack), 0);
    chk("t6_mem_we", 32'(mem_we), 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_we", 32'(mem_we), 0);
      chk("t6_idle_busy", 32'(busy), 0);
    end
    chk("t6_word", phys[5], old);
    chk("t6_ref", phys[5], ref_word(5));
    exp_rdata = 32'h0;
    chk("t6_rdata", rdata, 32'h0);

    // Random traffic over a small window, with random high bits to exercise wrap
    for (int k = 0; k < 120; k++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
